dmac_mem_responder: RTL and testbench
=====================================

// Module: dmac_mem_responder
// PURPOSE
//  Memory-side responder for the DMA controller's burst bus: accepts read/write burst
//  requests, serves read beats from / stores write beats into an internal word RAM.
//  Sits below the DMAC as the src/dst target in system and block-level benches.
//  Reports per-beat errors for misaligned and out-of-range addresses.
// PARAMETERS
//  ADDR_W    32      request byte-address width
//  DATA_W    32      data beat width (one word = DATA_W/8 bytes, must be 32)
//  LEN_W     16      burst length field width (beats)
//  DEPTH     1024    RAM depth in words
//  BASE_ADDR 0       byte address of RAM word 0
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       reset, asynchronous, active-high
//  req_valid   in   1       burst request valid
//  req_ready   out  1       responder can accept request
//  req_we      in   1       1 = write burst, 0 = read burst
//  req_addr    in   ADDR_W  start byte address
//  req_len     in   LEN_W   number of beats
//  wr_valid    in   1       write data beat valid
//  wr_ready    out  1       write beat accepted
//  wr_data     in   DATA_W  write data
//  rsp_valid   out  1       read data beat valid
//  rsp_ready   in   1       initiator accepts read beat
//  rsp_data    out  DATA_W  read data
//  rsp_last    out  1       final beat of read burst
//  rsp_err     out  1       this read beat is erroneous (rsp_data = 0)
//  wresp_valid out  1       write burst completion valid
//  wresp_ready in   1       initiator accepts completion
//  wresp_err   out  1       any beat of the write burst was erroneous
// BEHAVIOUR
//  - Reset (async): state=IDLE; req_ready, wr_ready, rsp_valid, rsp_last, rsp_err,
//    wresp_valid, wresp_err = 0; rsp_data = 0. RAM contents NOT cleared. Reset
//    mid-burst aborts burst; no further beats/completion for it.
//  - All handshakes: transfer when valid && ready at rising edge. Valid, once high,
//    holds with stable payload until accepted.
//  - FSM: IDLE -> (req accepted, we=0) RD; (we=1) WR. RD -> IDLE after last beat accepted.
//    WR -> WRESP after beat req_len accepted (or immediately if req_len==0);
//    WRESP -> IDLE when wresp accepted.
//  - req_ready = 1 only in IDLE with rst low; wr_ready = 1 only in WR.
//  - Request fields latched on accept. Beat address = req_addr + 4*i, i=0..req_len-1,
//    computed modulo 2^ADDR_W. Word index = (addr - BASE_ADDR) >> 2.
//  - Beat error: addr[1:0] != 0, addr < BASE_ADDR, or index >= DEPTH. Evaluated per
//    beat: no wrap inside RAM; a burst crossing end of RAM errors only beyond-end beats.
//  - Read: RAM read synchronous (1 cycle). First rsp_valid at earliest 2 cycles after
//    request accept. With rsp_ready held high, one beat per cycle, no bubbles.
//    rsp_ready low stalls without loss/duplication (skid/prefetch buffering internal).
//    rsp_last high only on beat req_len-1. Error beat: rsp_data=0, rsp_err=1.
//  - req_len==0 read: single beat, rsp_err=1, rsp_last=1, rsp_data=0.
//  - Write: beat i written to RAM on its accept edge; error beats discarded (RAM
//    untouched) but still consumed. wresp_err = OR of beat errors, or 1 if req_len==0.
//    wresp_valid rises the cycle after final beat accept (after request accept if len 0).
//  - Write then read of same word: read in a later burst always sees new data.
//  - rsp_* outputs hold 0 in IDLE/WR/WRESP; wresp_* hold 0 outside WRESP.
// TESTING
//  1 write burst addr=0x0 len=4 data 0x11,0x22,0x33,0x44; read back -> same 4 beats,
//    rsp_last on 4th, wresp_err=0, rsp_err=0.
//  2 read len=8 at 0x10, rsp_ready toggled 1-0-0-1 random -> 8 beats in order, none
//    lost/duplicated; with rsp_ready=1 beats on 8 consecutive cycles.
//  3 DEPTH=1024: read addr=0xFF8 len=4 -> beats 0,1 valid data, beats 2,3 rsp_err=1 data 0;
//    write same range -> wresp_err=1, words 0x3FE/0x3FF updated, nothing else.
//  4 misaligned addr=0x2 read len=2 -> both beats rsp_err=1; write len=2 -> wresp_err=1,
//    RAM unchanged.
//  5 req_len=0: read -> 1 beat err=1 last=1; write -> wresp_err=1, wr_ready never high.
//  6 assert rst during 3rd beat of len=16 read -> outputs 0 async, req_ready=1 after
//    release, new read of earlier-written word returns stored data.

Source files
------------

// File: rtl/dmac_mem_if.sv
// Burst bus between the DMA controller (master) and a memory responder (slave):
// request channel, write-data channel, read-response channel, write-completion channel.
interface dmac_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              rsp_err;
  logic              wresp_valid;
  logic              wresp_ready;
  logic              wresp_err;

  modport master (
    output req_valid, req_we, req_addr, req_len, wr_valid, wr_data, rsp_ready, wresp_ready,
    input  req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, rsp_err, wresp_valid, wresp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data, rsp_ready, wresp_ready,
    output req_ready, wr_ready, rsp_valid, rsp_data, rsp_last, rsp_err, wresp_valid, wresp_err
  );
endinterface

// File: rtl/dmac_mem_responder.sv
// Memory-side burst responder: serves read bursts from and stores write bursts into
// an internal word RAM, flagging misaligned / out-of-range beats as errors.
// Reads are prefetched into a 2-entry output FIFO so a stalled initiator never loses
// a beat and an always-ready initiator sees one beat per cycle.
module dmac_mem_responder #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          LEN_W     = 16,
  parameter int          DEPTH     = 1024,
  parameter int unsigned BASE_ADDR = 0
) (
  input logic      clk,
  input logic      rst,
  dmac_mem_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;
  state_t state, state_next;

  // Latched burst context; beat_cnt counts issued read beats or accepted write beats.
  logic [ADDR_W-1:0] beat_addr;
  logic [LEN_W-1:0]  burst_len;   // zero-length reads are served as one beat
  logic [LEN_W-1:0]  beat_cnt;
  logic              zero_len;
  logic              werr;

  // Per-beat address decode
  logic [ADDR_W:0]   diff;
  logic [ADDR_W-1:0] word;
  logic [IDX_W-1:0]  idx;
  logic              beat_err;

  // Read pipeline: RAM output stage, then 2-entry FIFO feeding the response port
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic              pend_valid, pend_err, pend_last;
  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_err  [2];
  logic              fifo_last [2];
  logic              wptr, rptr;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;

  logic accept, rd_issue, rd_en, wr_beat, ram_we, pop, rsp_valid;

  assign diff     = {1'b0, beat_addr} - {1'b0, BASE_A};
  assign word     = diff[ADDR_W-1:0] >> 2;
  assign idx      = word[IDX_W-1:0];
  assign beat_err = zero_len || (beat_addr[1:0] != 2'b00) || diff[ADDR_W] || (word >= DEPTH_A);

  assign rsp_valid = (fifo_cnt != 2'd0);
  assign pop       = rsp_valid && bus.rsp_ready;
  assign occ       = {1'b0, fifo_cnt} + {2'b00, pend_valid};
  assign accept    = (state == IDLE) && bus.req_valid;
  assign rd_issue  = (state == RD) && (beat_cnt != burst_len) && ((occ < 3'd2) || pop);
  assign rd_en     = rd_issue && !beat_err;
  assign wr_beat   = (state == WR) && bus.wr_valid;
  assign ram_we    = wr_beat && !beat_err;

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_valid ? fifo_data[rptr] : '0;
  assign bus.rsp_err   = rsp_valid && fifo_err[rptr];
  assign bus.rsp_last  = rsp_valid && fifo_last[rptr];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake-ready/completion outputs
  always_comb begin
    state_next      = state;
    bus.req_ready   = 1'b0;
    bus.wr_ready    = 1'b0;
    bus.wresp_valid = 1'b0;
    bus.wresp_err   = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = !rst;
        if (bus.req_valid) begin
          if (!bus.req_we)              state_next = RD;
          else if (bus.req_len == '0)   state_next = WRESP;
          else                          state_next = WR;
        end
      end
      RD: begin
        if (pop && fifo_last[rptr]) state_next = IDLE;
      end
      WR: begin
        bus.wr_ready = 1'b1;
        if (bus.wr_valid && (beat_cnt == burst_len - LEN_W'(1))) state_next = WRESP;
      end
      WRESP: begin
        bus.wresp_valid = 1'b1;
        bus.wresp_err   = werr;
        if (bus.wresp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Burst context: latch on accept, advance one word per issued/accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_addr <= '0;
      burst_len <= '0;
      beat_cnt  <= '0;
      zero_len  <= 1'b0;
      werr      <= 1'b0;
    end else if (accept) begin
      beat_addr <= bus.req_addr;
      burst_len <= (bus.req_len == '0) ? LEN_W'(1) : bus.req_len;
      zero_len  <= (bus.req_len == '0);
      beat_cnt  <= '0;
      werr      <= (bus.req_len == '0);
    end else if (rd_issue || wr_beat) begin
      beat_addr <= beat_addr + ADDR_W'(4);
      beat_cnt  <= beat_cnt + LEN_W'(1);
      if (wr_beat) werr <= werr | beat_err;
    end
  end

  // Word RAM: write on beat accept, registered read for prefetch
  always_ff @(posedge clk) begin
    if (ram_we) ram[idx] <= bus.wr_data;
    if (rd_en)  ram_q    <= ram[idx];
  end

  // Read-beat tracking through the RAM stage and into the response FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_err   <= 1'b0;
      pend_last  <= 1'b0;
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      fifo_cnt   <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_err[i]  <= 1'b0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      pend_valid <= rd_issue;
      pend_err   <= beat_err;
      pend_last  <= (beat_cnt == burst_len - LEN_W'(1));
      if (pend_valid) begin
        fifo_data[wptr] <= pend_err ? '0 : ram_q;
        fifo_err[wptr]  <= pend_err;
        fifo_last[wptr] <= pend_last;
        wptr            <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      if (pend_valid && !pop)      fifo_cnt <= fifo_cnt + 2'd1;
      else if (!pend_valid && pop) fifo_cnt <= fifo_cnt - 2'd1;
    end
  end
endmodule

// File: tb/tb_dmac_mem_responder.sv
// Randomized scoreboard bench for dmac_mem_responder: stimulus pushes expected beats and
// completions computed from a word-array memory model; a monitor pops and compares.
module tb_dmac_mem_responder;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int DEPTH  = 1024;
  localparam longint BASE = 0;
  localparam int TMO = 200;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  dmac_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus();

  dmac_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .BASE_ADDR(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_model [DEPTH];
  exp_t        rd_q [$];
  bit          wr_q [$];
  int          rd_seen = 0;
  bit          track = 0;
  int          beat_cyc [$];
  int          cyc = 0;
  bit          rdy_mode = 1'b1;
  exp_t        e;
  bit          we_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte address -> error / word index, straight from the address map rules
  function automatic bit addr_bad(input logic [31:0] a);
    longint off;
    off = longint'({32'd0, a}) - BASE;
    if (a[1:0] != 2'b00) return 1'b1;
    if (off < 0) return 1'b1;
    if (off / 4 >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((longint'({32'd0, a}) - BASE) / 4);
  endfunction

  // Initiator back-pressure on response channels
  initial begin
    bus.rsp_ready   = 1'b1;
    bus.wresp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.rsp_ready   = rdy_mode ? 1'b1 : 1'($urandom_range(0, 1));
      bus.wresp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compare every transferred read beat and write completion
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.rsp_valid && bus.rsp_ready) begin
          rd_seen++;
          if (track) beat_cyc.push_back(cyc);
          checks++;
          if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected got data=%h err=%b last=%b, none expected",
                     bus.rsp_data, bus.rsp_err, bus.rsp_last);
          end else begin
            e = rd_q.pop_front();
            if (bus.rsp_data !== e.data || bus.rsp_err !== e.err || bus.rsp_last !== e.last) begin
              errors++;
              $display("FAIL rsp_beat got data=%h err=%b last=%b exp data=%h err=%b last=%b",
                       bus.rsp_data, bus.rsp_err, bus.rsp_last, e.data, e.err, e.last);
            end
          end
        end
        if (bus.wresp_valid && bus.wresp_ready) begin
          checks++;
          if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL wresp_unexpected got err=%b, none expected", bus.wresp_err);
          end else begin
            we_exp = wr_q.pop_front();
            if (bus.wresp_err !== we_exp) begin
              errors++;
              $display("FAIL wresp_err got %b exp %b", bus.wresp_err, we_exp);
            end
          end
        end
      end
    end
  end

  task automatic send_req(input logic we, input logic [31:0] addr, input logic [15:0] len);
    bit ok;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_len   = len;
    for (int n = 0; n < TMO && !ok; n++) begin
      @(negedge clk);
      ok = bus.req_ready;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_accept got no req_ready within %0d cycles, required accept", TMO);
    end
  endtask

  task automatic rd_burst(input logic [31:0] addr, input int len);
    logic [31:0] a;
    exp_t x;
    if (len == 0) begin
      x.data = '0; x.err = 1'b1; x.last = 1'b1;
      rd_q.push_back(x);
    end
    for (int i = 0; i < len; i++) begin
      a = addr + 32'(4 * i);
      x.last = (i == len - 1);
      if (addr_bad(a)) begin
        x.data = '0; x.err = 1'b1;
      end else begin
        x.data = mem_model[word_idx(a)]; x.err = 1'b0;
      end
      rd_q.push_back(x);
    end
    $display("RD  addr=%h len=%0d", addr, len);
    send_req(1'b0, addr, 16'(len));
  endtask

  task automatic wr_burst(input logic [31:0] addr, input logic [31:0] dq [$]);
    int len;
    logic [31:0] a;
    bit err_any, ok;
    len = dq.size();
    err_any = (len == 0);
    for (int i = 0; i < len; i++) begin
      a = addr + 32'(4 * i);
      if (addr_bad(a)) err_any = 1'b1;
      else mem_model[word_idx(a)] = dq[i];
    end
    wr_q.push_back(err_any);
    $display("WR  addr=%h len=%0d exp_err=%b", addr, len, err_any);
    send_req(1'b1, addr, 16'(len));
    if (len == 0) begin
      for (int n = 0; n < 3; n++) begin
        @(negedge clk);
        checks++;
        if (bus.wr_ready !== 1'b0) begin
          errors++;
          $display("FAIL wr_ready_len0 got %b required 0", bus.wr_ready);
        end
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = dq[i];
      ok = 1'b0;
      for (int n = 0; n < TMO && !ok; n++) begin
        @(negedge clk);
        ok = bus.wr_ready;
        @(posedge clk); #1;
      end
      bus.wr_valid = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL wr_beat %0d got no wr_ready, required accept", i);
      end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20000 && !ok; n++) begin
      @(negedge clk); #1;
      ok = (rd_q.size() == 0) && (wr_q.size() == 0) && bus.req_ready;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout got rd_left=%0d wr_left=%0d required 0/0",
               rd_q.size(), wr_q.size());
      rd_q.delete();
      wr_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got no finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dq [$];
    logic [31:0] addr;
    int base, len, sel;
    bit ok;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b0 || bus.wr_ready !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_data !== '0 || bus.rsp_last !== 1'b0 || bus.rsp_err !== 1'b0 ||
        bus.wresp_valid !== 1'b0 || bus.wresp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got req_rdy=%b wr_rdy=%b rsp_v=%b data=%h wresp_v=%b required all 0",
               bus.req_ready, bus.wr_ready, bus.rsp_valid, bus.rsp_data, bus.wresp_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b required 1", bus.req_ready);
    end
    @(posedge clk); #1;

    // Fill the whole RAM so every later read has a known expectation
    dq = {};
    for (int i = 0; i < DEPTH; i++) dq.push_back($urandom);
    wr_burst(32'h0, dq);
    wait_idle();

    // Basic write / read-back
    dq = {32'h11, 32'h22, 32'h33, 32'h44};
    wr_burst(32'h0, dq);
    rd_burst(32'h0, 4);
    wait_idle();

    // Back-to-back beats with ready held high, then random stalls
    rdy_mode = 1'b1;
    beat_cyc.delete();
    track = 1'b1;
    rd_burst(32'h10, 8);
    wait_idle();
    track = 1'b0;
    checks++;
    ok = (beat_cyc.size() == 8);
    for (int i = 1; i < beat_cyc.size(); i++) if (beat_cyc[i] != beat_cyc[i-1] + 1) ok = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL rd_back_to_back got %0d beats span %0d cycles required 8 beats on 8 consecutive cycles",
               beat_cyc.size(), beat_cyc.size() > 0 ? beat_cyc[$] - beat_cyc[0] + 1 : 0);
    end
    rdy_mode = 1'b0;
    rd_burst(32'h10, 8);
    wait_idle();

    // End-of-RAM crossing, misaligned, zero-length
    rd_burst(32'hFF8, 4);
    dq = {32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003, 32'hA0A0_0004};
    wr_burst(32'hFF8, dq);
    rd_burst(32'hFF0, 4);
    rd_burst(32'h2, 2);
    dq = {32'hDEAD_0001, 32'hDEAD_0002};
    wr_burst(32'h2, dq);
    rd_burst(32'h0, 2);
    rd_burst(32'h40, 0);
    dq = {};
    wr_burst(32'h40, dq);
    wait_idle();

    // Randomized mix including address wrap and beyond-end starts
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      len = $urandom_range(0, 12);
      rdy_mode = 1'($urandom_range(0, 1));
      if (sel <= 5)      addr = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      else if (sel == 6) addr = 32'hFE0 + 32'(4 * $urandom_range(0, 7));
      else if (sel == 7) addr = 32'($urandom_range(0, 4095));
      else if (sel == 8) addr = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
      else               addr = 32'h1000 + 32'(4 * $urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        dq = {};
        for (int i = 0; i < len; i++) dq.push_back($urandom);
        wr_burst(addr, dq);
      end else begin
        rd_burst(addr, len);
      end
    end
    wait_idle();

    // Asynchronous reset in the middle of a long read
    rdy_mode = 1'b1;
    base = rd_seen;
    rd_burst(32'h40, 16);
    ok = 1'b0;
    for (int n = 0; n < TMO && !ok; n++) begin
      @(negedge clk); #1;
      ok = (rd_seen >= base + 3);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_setup got %0d beats required 3", rd_seen - base);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== '0 || bus.rsp_last !== 1'b0 ||
        bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0 || bus.wresp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async got rsp_v=%b data=%h last=%b err=%b req_rdy=%b required all 0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_last, bus.rsp_err, bus.req_ready);
    end
    rd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready got %0b required 1", bus.req_ready);
    end
    @(posedge clk); #1;
    rdy_mode = 1'b0;
    rd_burst(32'h0, 4);
    wait_idle();

    // Full read-back catches any stray or missing RAM update
    rd_burst(32'h0, DEPTH);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
